aes_inv_cipher_core: RTL

//  AES-128 inverse cipher (decrypt) datapath and sequencer. It is the receive-side counterpart of the encrypt round core.

---
 rtl/aes_inv_cipher_core.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher_core.sv
// AES-128 inverse cipher with an on-chip key schedule. The schedule is expanded
// forward to round key 10, then stepped backwards one round at a time.
module aes_inv_cipher_core #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] pt,
    output logic [3:0]   round
);

    if (NR != 10) begin : g_nr_check
        $error("aes_inv_cipher_core supports only NR=10 (AES-128)");
    end

    localparam logic [3:0] NR_4 = 4'(NR);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {IDLE, KEXP, ADD, ISH, ISB, IMX, DONE} state_t;

    state_t       state;
    logic [127:0] st;
    logic [127:0] rk;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] v0, v1, v2, v3;
        v0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        v1 = k[95:64] ^ v0;
        v2 = k[63:32] ^ v1;
        v3 = k[31:0] ^ v2;
        return {v0, v1, v2, v3};
    endfunction

    function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] v0, v1, v2, v3;
        v3 = k[31:0] ^ k[63:32];
        v2 = k[63:32] ^ k[95:64];
        v1 = k[95:64] ^ k[127:96];
        v0 = k[127:96] ^ sub_rot_word(v3) ^ {rc, 24'h0};
        return {v0, v1, v2, v3};
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant whose bits select a, 2a, 4a, 8a (covers 09/0b/0d/0e).
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++)
                a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = gm(a[r], 4'he) ^ gm(a[(r+1)%4], 4'hb)
                                      ^ gm(a[(r+2)%4], 4'hd) ^ gm(a[(r+3)%4], 4'h9);
        end
        return o;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            rk    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pt    <= '0;
            round <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    st    <= ct;
                    rk    <= key;
                    round <= 4'd1;
                    busy  <= 1'b1;
                    state <= KEXP;
                end
                KEXP: begin
                    rk <= fwd_expand(rk, rcon(round));
                    if (round == NR_4) state <= ADD;
                    else               round <= round + 4'd1;
                end
                ADD: begin
                    st <= st ^ rk;
                    if (round == NR_4) begin
                        round <= NR_4 - 4'd1;
                        state <= ISH;
                    end else if (round == 4'd0) begin
                        // Publish the result together with the done pulse.
                        pt    <= st ^ rk;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= IMX;
                    end
                end
                ISH: begin
                    st    <= inv_shift_rows(st);
                    state <= ISB;
                end
                ISB: begin
                    st    <= inv_sub_bytes(st);
                    rk    <= inv_expand(rk, rcon(round + 4'd1));
                    state <= ADD;
                end
                IMX: begin
                    st    <= inv_mix_columns(st);
                    round <= round - 4'd1;
                    state <= ISH;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
